// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and interrupt controller.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int ECALL_CAUSE  = 11;
  localparam int IDX_W        = 4;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/irq_pending.sv
// Rising-edge capture of external requests into pending bits, plus a
// lowest-index-wins priority encoder over the enabled pending set.
module irq_pending
  import csr_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] mask_i,
  input  logic             clr_i,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] sel_o,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] pend_d;
  logic [N_IRQ-1:0] elig;

  assign elig      = pend_q & mask_i;
  assign any_o     = |elig;
  assign pending_o = pend_q;

  // A new edge on the channel being cleared wins, so the request is not lost.
  always_comb begin
    idx_o = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) idx_o = IDX_W'(i);
    end
    sel_o = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      sel_o[i] = any_o && (idx_o == IDX_W'(i));
    end
    pend_d = (pend_q & ~({N_IRQ{clr_i}} & sel_o)) | (irq_i & ~prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= irq_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with vectored interrupt entry, ecall/mret sequencing
// and a post-redirect drain window during which commits are ignored.
//
//   state    | meaning
//   ST_RUN   | accepting traps, mret and CSR writes at commit
//   ST_DRAIN | pipeline flushing after a redirect; commits ignored
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int N_IRQ     = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [N_IRQ-1:0] irq_ack,
  input  logic             commit_ok,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             ecall,
  input  logic             mret,
  input  logic             csrrw,
  input  logic             csrrsi,
  input  logic             csrrci,
  input  logic [11:0]      csr_addr,
  input  logic [XLEN-1:0]  csr_wdata,
  output logic [XLEN-1:0]  csr_rdata,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             busy
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e           state_q;
  logic [CW-1:0]    drain_q;
  logic             mstat_mie_q, mstat_mpie_q;
  logic [N_IRQ-1:0] mie_q;
  logic [XLEN-1:0]  mtvec_q, mepc_q, mcause_q;
  logic             redirect_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [N_IRQ-1:0] irq_ack_q;

  logic [N_IRQ-1:0] pending, irq_sel;
  logic             irq_any;
  logic [IDX_W-1:0] irq_idx;

  logic             run_ok, take_ecall, take_irq, take_mret, take_trap, take_any, csr_we;
  logic [XLEN-1:0]  csr_wr_d, mtvec_base, target_d;

  irq_pending #(.N_IRQ(N_IRQ)) u_pending (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_i    (irq_in),
    .mask_i   (mie_q),
    .clr_i    (take_irq),
    .pending_o(pending),
    .sel_o    (irq_sel),
    .any_o    (irq_any),
    .idx_o    (irq_idx)
  );

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = mstat_mie_q;
        csr_rdata[MSTATUS_MPIE] = mstat_mpie_q;
      end
      CSR_MIE:    csr_rdata[N_IRQ-1:0] = mie_q;
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MIP:    csr_rdata[N_IRQ-1:0] = pending;
      default:    csr_rdata = '0;
    endcase
  end

  // Priority at commit: ecall, then enabled interrupt, then mret, then CSR op.
  always_comb begin
    run_ok     = (state_q == ST_RUN) && commit_ok;
    take_ecall = run_ok && ecall;
    take_irq   = run_ok && !ecall && mstat_mie_q && irq_any;
    take_mret  = run_ok && !ecall && !take_irq && mret;
    take_trap  = take_ecall || take_irq;
    take_any   = take_trap || take_mret;
    csr_we     = run_ok && !take_any && (csrrw || csrrsi || csrrci);
    if (csrrw)       csr_wr_d = csr_wdata;
    else if (csrrsi) csr_wr_d = csr_rdata | csr_wdata;
    else             csr_wr_d = csr_rdata & ~csr_wdata;
    mtvec_base = mtvec_q & ~XLEN'(3);
    if (take_mret)                 target_d = mepc_q;
    else if (take_irq && mtvec_q[0]) target_d = mtvec_base + XLEN'({irq_idx, 2'b00});
    else                           target_d = mtvec_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      drain_q       <= '0;
      mstat_mie_q   <= 1'b0;
      mstat_mpie_q  <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      irq_ack_q     <= '0;
    end else begin
      redirect_q <= take_any;
      irq_ack_q  <= take_irq ? irq_sel : '0;
      if (take_any) redirect_pc_q <= target_d;

      case (state_q)
        ST_RUN: begin
          if (take_any) begin
            state_q <= ST_DRAIN;
            drain_q <= CW'(DRAIN_CYC - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_q <= ST_RUN;
          else               drain_q <= drain_q - 1'b1;
        end
        default: state_q <= ST_RUN;
      endcase

      if (take_trap) begin
        mepc_q       <= pc_in & ~XLEN'(3);
        mcause_q     <= take_ecall ? XLEN'(ECALL_CAUSE)
                                   : {1'b1, {(XLEN-1-IDX_W){1'b0}}, irq_idx};
        mstat_mpie_q <= mstat_mie_q;
        mstat_mie_q  <= 1'b0;
      end else if (take_mret) begin
        mstat_mie_q  <= mstat_mpie_q;
        mstat_mpie_q <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstat_mie_q  <= csr_wr_d[MSTATUS_MIE];
            mstat_mpie_q <= csr_wr_d[MSTATUS_MPIE];
          end
          CSR_MIE:    mie_q    <= csr_wr_d[N_IRQ-1:0];
          CSR_MTVEC:  mtvec_q  <= {csr_wr_d[XLEN-1:2], 1'b0, csr_wr_d[0]};
          CSR_MEPC:   mepc_q   <= csr_wr_d & ~XLEN'(3);
          CSR_MCAUSE: mcause_q <= csr_wr_d;
          default: ;
        endcase
      end
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign irq_ack     = irq_ack_q;
  assign busy        = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_csr_irq_unit.sv
// Self-checking bench for csr_irq_unit: directed scenarios plus random
// traffic, all compared against a cycle-level reference model.
module tb_csr_irq_unit;

  localparam int XLEN = 32, N_IRQ = 4, DRAIN_CYC = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N_IRQ-1:0] irq_in = '0, irq_ack;
  logic commit_ok = 0, ecall = 0, mret = 0, csrrw = 0, csrrsi = 0, csrrci = 0;
  logic [XLEN-1:0] pc_in = '0, csr_wdata = '0, csr_rdata, redirect_pc;
  logic [11:0] csr_addr = '0;
  logic redirect, busy;

  csr_irq_unit #(.XLEN(XLEN), .N_IRQ(N_IRQ), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_ack(irq_ack),
    .commit_ok(commit_ok), .pc_in(pc_in), .ecall(ecall), .mret(mret),
    .csrrw(csrrw), .csrrsi(csrrsi), .csrrci(csrrci), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit        m_mstat, m_mpie;
  bit [3:0]  m_mie, m_pend, m_prev;
  bit [31:0] m_mtvec, m_mepc, m_mcause;
  int        blk;
  logic [31:0] last_rd;
  bit [3:0]  irq_cur;
  logic [11:0] addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};

  function automatic bit [31:0] mread(input bit [11:0] a);
    case (a)
      12'h300: return (32'(m_mpie) << 7) | (32'(m_mstat) << 3);
      12'h304: return 32'(m_mie);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return 32'(m_pend);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_mstat = 0; m_mpie = 0; m_mie = 0; m_pend = 0; m_prev = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; blk = 0;
  endtask

  // op: 0 none, 1 CSRRW, 2 CSRRSI, 3 CSRRCI
  task automatic step(input bit co, input bit [31:0] pc, input bit ec, input bit mr,
                      input bit [1:0] op, input bit [11:0] a, input bit [31:0] wd,
                      input bit [3:0] irq);
    bit [31:0] old, nv, e_rpc, n_mtvec, n_mepc, n_mcause;
    bit        e_red, can, n_mstat, n_mpie;
    bit [3:0]  e_ack, clr, rise, n_mie;
    int        win;
    @(negedge clk);
    commit_ok = co; pc_in = pc; ecall = ec; mret = mr;
    csrrw = (op == 2'd1); csrrsi = (op == 2'd2); csrrci = (op == 2'd3);
    csr_addr = a; csr_wdata = wd; irq_in = irq;
    #1;
    old = mread(a);
    last_rd = csr_rdata;
    chk("csr_rdata", csr_rdata, old);

    rise = irq & ~m_prev;
    win = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mie[i]) win = i;
    can = (blk == 0) && co;
    n_mstat = m_mstat; n_mpie = m_mpie; n_mie = m_mie;
    n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
    e_red = 0; e_rpc = 0; e_ack = 0; clr = 0;
    if (can && ec) begin
      e_red = 1; e_rpc = m_mtvec & ~32'h3;
      n_mepc = pc & ~32'h3; n_mcause = 32'd11; n_mpie = m_mstat; n_mstat = 0;
    end else if (can && m_mstat && win >= 0) begin
      e_red = 1;
      e_rpc = (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(4 * win) : 32'h0);
      n_mepc = pc & ~32'h3; n_mcause = 32'h8000_0000 | 32'(win);
      n_mpie = m_mstat; n_mstat = 0;
      clr[win] = 1'b1; e_ack = clr;
    end else if (can && mr) begin
      e_red = 1; e_rpc = m_mepc; n_mstat = m_mpie; n_mpie = 1;
    end else if (can && op != 0) begin
      nv = (op == 1) ? wd : (op == 2) ? (old | wd) : (old & ~wd);
      case (a)
        12'h300: begin n_mstat = nv[3]; n_mpie = nv[7]; end
        12'h304: n_mie = nv[3:0];
        12'h305: n_mtvec = nv & 32'hFFFF_FFFD;
        12'h341: n_mepc = nv & ~32'h3;
        12'h342: n_mcause = nv;
        default: ;
      endcase
    end

    @(posedge clk);
    #1;
    m_mstat = n_mstat; m_mpie = n_mpie; m_mie = n_mie;
    m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq;
    blk = e_red ? DRAIN_CYC : (blk > 0 ? blk - 1 : 0);
    chk("redirect", 32'(redirect), 32'(e_red));
    if (e_red) chk("redirect_pc", redirect_pc, e_rpc);
    chk("irq_ack", 32'(irq_ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(blk > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 12'h000, 0, irq_cur);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 0;
    commit_ok = 0; ecall = 0; mret = 0; csrrw = 0; csrrsi = 0; csrrci = 0;
    irq_in = '0; irq_cur = '0;
    #1;
    model_clear();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_irq_ack", 32'(irq_ack), 32'h0);
    for (int i = 0; i < 6; i++) begin
      csr_addr = addrs[i];
      #1;
      chk("rst_csr", csr_rdata, 32'h0);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bit [1:0] op;
    bit [11:0] a;
    model_clear();
    apply_reset();

    // CSRRSI / CSRRCI on mstatus, mip read-only
    step(1, 0, 0, 0, 2, 12'h300, 32'd8, 0);  chk("rsi_old", last_rd, 32'h0);
    step(0, 0, 0, 0, 0, 12'h300, 0, 0);      chk("mie_set", last_rd, 32'h8);
    step(1, 0, 0, 0, 3, 12'h300, 32'd8, 0);  chk("rci_old", last_rd, 32'h8);
    step(0, 0, 0, 0, 0, 12'h300, 0, 0);      chk("mie_clr", last_rd, 32'h0);
    step(1, 0, 0, 0, 1, 12'h344, 32'hF, 0);
    step(0, 0, 0, 0, 0, 12'h344, 0, 0);      chk("mip_ro", last_rd, 32'h0);

    // Interrupt pending while MIE=0, then enabled
    step(1, 0, 0, 0, 1, 12'h304, 32'hF, 0);
    step(1, 0, 0, 0, 1, 12'h305, 32'h100, 0);
    irq_cur = 4'b0100;
    step(0, 0, 0, 0, 0, 12'h000, 0, irq_cur);
    step(1, 32'h40, 0, 0, 0, 12'h000, 0, irq_cur); chk("no_trap_mie0", 32'(redirect), 32'h0);
    step(1, 32'h40, 0, 0, 2, 12'h300, 32'd8, irq_cur);
    step(1, 32'h40, 0, 0, 0, 12'h000, 0, irq_cur);
    chk("irq2_redir", 32'(redirect), 32'h1);
    chk("irq2_pc", redirect_pc, 32'h100);
    chk("irq2_ack", 32'(irq_ack), 32'h4);
    step(0, 0, 0, 0, 0, 12'h341, 0, irq_cur); chk("irq2_mepc", last_rd, 32'h40);
    step(0, 0, 0, 0, 0, 12'h342, 0, irq_cur); chk("irq2_mcause", last_rd, 32'h8000_0002);
    step(0, 0, 0, 0, 0, 12'h300, 0, irq_cur); chk("irq2_mstatus", last_rd, 32'h80);

    // Vectored mode, simultaneous edges on ch1 and ch3
    step(1, 0, 0, 0, 1, 12'h305, 32'h101, irq_cur);
    step(1, 32'h44, 0, 1, 0, 12'h000, 0, irq_cur); chk("mret_pc", redirect_pc, 32'h40);
    idle(DRAIN_CYC);
    irq_cur = 4'b0000; idle(1);
    irq_cur = 4'b1010; idle(1);
    step(1, 32'h50, 0, 0, 0, 12'h000, 0, irq_cur);
    chk("ch1_pc", redirect_pc, 32'h104);
    chk("ch1_ack", 32'(irq_ack), 32'h2);
    idle(DRAIN_CYC);
    step(1, 32'h54, 0, 1, 0, 12'h000, 0, irq_cur);
    idle(DRAIN_CYC);
    step(1, 32'h60, 0, 0, 0, 12'h000, 0, irq_cur);
    chk("ch3_pc", redirect_pc, 32'h10C);
    chk("ch3_ack", 32'(irq_ack), 32'h8);

    // ecall beats a pending interrupt
    idle(DRAIN_CYC);
    step(1, 32'h64, 0, 1, 0, 12'h000, 0, irq_cur);
    idle(DRAIN_CYC);
    irq_cur = 4'b1011; idle(1);
    step(1, 32'h80, 1, 0, 0, 12'h000, 0, irq_cur);
    chk("ecall_pc", redirect_pc, 32'h100);
    step(0, 0, 0, 0, 0, 12'h342, 0, irq_cur); chk("ecall_mcause", last_rd, 32'd11);
    step(0, 0, 0, 0, 0, 12'h341, 0, irq_cur); chk("ecall_mepc", last_rd, 32'h80);
    step(0, 0, 0, 0, 0, 12'h344, 0, irq_cur); chk("ecall_mip", last_rd, 32'h1);

    // Reset in the middle of a drain window
    step(1, 32'h84, 0, 1, 0, 12'h000, 0, irq_cur);
    idle(1);
    chk("busy_pre_rst", 32'(busy), 32'h1);
    apply_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h90, 0, 0, 0, 12'h300, 0, irq_cur);
    chk("post_rst_redir", 32'(redirect), 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) irq_cur = irq_cur ^ 4'($urandom_range(0, 15));
      r = $urandom_range(0, 5);
      op = (r <= 3) ? 2'(r) : 2'd0;
      a = addrs[$urandom_range(0, 6)];
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
           $urandom_range(0, 9) == 0, op, a,
           (op == 2'd1) ? $urandom : 32'($urandom_range(0, 31)), irq_cur);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
